binarization_decode: RTL and testbench

Multi-cycle decoder that turns per-lane thermometer-coded channel vectors back into signed pixel values. It reverses the input binarization stage: a lane whose code holds N ones, packed from the LSB, decodes to N − CHANNEL_CNT/2. It sits at the network output / debug tap, after the binarized feature path, and uses a valid/ready handshake on both sides. Ones are counted CHUNK bits per cycle so that all KERNEL_SIZE lanes share a shallow adder tree.

---
 rtl/binarization_decode_pkg.sv | 34 +++
 rtl/binarization_decode_if.sv | 44 ++++
 rtl/binarization_decode_popcount_chunk.sv | 19 +
 rtl/binarization_decode.sv | 145 ++++++++++++++
 tb/tb_binarization_decode.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/binarization_decode_pkg.sv
// binarization_pkg: shared constants, FSM state type and helpers for the
// binarization_decode block.
//   KERNEL_SIZE / BIT_WIDTH / CHANNEL_CNT : default lane count, pixel width,
//                                           thermometer code length
//   state_t      : decoder FSM states
//   count_width  : bits needed to hold a count of 0..n
//   saturate     : clamp an integer into a signed bw-bit range
package binarization_pkg;

  localparam int KERNEL_SIZE = 9;
  localparam int BIT_WIDTH   = 8;
  localparam int CHANNEL_CNT = 256;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int saturate(input int v, input int bw);
    int hi;
    int lo;
    hi = (1 << (bw - 1)) - 1;
    lo = -(1 << (bw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/binarization_decode_if.sv
// binarization_decode_if: valid/ready bundle around the decoder.
//   in_valid/in_ready/code_in       : thermometer-code vector input
//   out_valid/out_ready/pixel_out   : decoded signed pixel output
//   out_err                         : per-lane malformed-code flag, present
//                                     only with BINARIZATION_DECODE_CHECK_EN
// Modports: master = producer/consumer side (bench), slave = decoder.
interface binarization_decode_if #(
  parameter int KERNEL_SIZE = binarization_pkg::KERNEL_SIZE,
  parameter int BIT_WIDTH   = binarization_pkg::BIT_WIDTH,
  parameter int CHANNEL_CNT = binarization_pkg::CHANNEL_CNT
);

  logic                                    in_valid;
  logic                                    in_ready;
  logic [KERNEL_SIZE-1:0][CHANNEL_CNT-1:0] code_in;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [KERNEL_SIZE-1:0][BIT_WIDTH-1:0]   pixel_out;

`ifdef BINARIZATION_DECODE_CHECK_EN
  logic [KERNEL_SIZE-1:0]                  out_err;

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, pixel_out, out_err
  );

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, pixel_out, out_err
  );
`else
  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, pixel_out
  );

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, pixel_out
  );
`endif

endinterface

// File: rtl/binarization_decode_popcount_chunk.sv
// popcount_chunk: combinational count of set bits in a CHUNK-bit slice.
//   bits  : input slice
//   count : number of ones, $clog2(CHUNK+1) bits
module popcount_chunk #(
  parameter int CHUNK = 32,
  parameter int OUT_W = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [OUT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      count = count + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/binarization_decode.sv
// binarization_decode: converts per-lane LSB-packed thermometer codes back
// into signed pixels (ones - CHANNEL_CNT/2, saturated to BIT_WIDTH).
// A captured vector is counted CHUNK bits per cycle over NCHUNK cycles, then
// the result is held in DONE until the consumer takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   io         : binarization_decode_if.slave (input and output handshakes)
// Optional feature macro: BINARIZATION_DECODE_CHECK_EN adds per-lane
// malformed-code detection driven onto io.out_err.
module binarization_decode #(
  parameter int KERNEL_SIZE = binarization_pkg::KERNEL_SIZE,
  parameter int BIT_WIDTH   = binarization_pkg::BIT_WIDTH,
  parameter int CHANNEL_CNT = binarization_pkg::CHANNEL_CNT,
  parameter int CHUNK       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  binarization_decode_if.slave  io
);

  import binarization_pkg::*;

  localparam int NCHUNK = CHANNEL_CNT / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = count_width(CHANNEL_CNT);
  localparam int PCW    = count_width(CHUNK);

  state_t state, state_next;

  logic [KERNEL_SIZE-1:0][CHANNEL_CNT-1:0] buffer;
  logic [KERNEL_SIZE-1:0][CW-1:0]          cnt;
  logic [KERNEL_SIZE-1:0][CW-1:0]          cnt_next;
  logic [KERNEL_SIZE-1:0][CHUNK-1:0]       chunk_bits;
  logic [KERNEL_SIZE-1:0][PCW-1:0]         pc;
  logic [KERNEL_SIZE-1:0][BIT_WIDTH-1:0]   pix_next;
  logic [IW-1:0]                           idx;
  logic                                    last_chunk;

  assign last_chunk = (idx == IW'(NCHUNK - 1));

  for (genvar g = 0; g < KERNEL_SIZE; g++) begin : g_lane
    assign chunk_bits[g] = buffer[g][idx*CHUNK +: CHUNK];

    popcount_chunk #(.CHUNK(CHUNK), .OUT_W(PCW)) u_popcount (
      .bits  (chunk_bits[g]),
      .count (pc[g])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (io.in_valid)  state_next = ACCUM;
      ACCUM:   if (last_chunk)   state_next = DONE;
      DONE:    if (io.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
  end

  // Running count including the chunk being summed this cycle, so the final
  // pixel can be registered on the same edge that enters DONE.
  always_comb begin
    for (int unsigned l = 0; l < KERNEL_SIZE; l++) begin
      cnt_next[l] = cnt[l] + CW'(pc[l]);
      pix_next[l] = BIT_WIDTH'(saturate(int'(cnt_next[l]) - CHANNEL_CNT / 2,
                                        BIT_WIDTH));
    end
  end

`ifdef BINARIZATION_DECODE_CHECK_EN
  logic [KERNEL_SIZE-1:0] zero_seen, zero_seen_next;
  logic [KERNEL_SIZE-1:0] err_acc, err_next;

  // Scan the current chunk LSB to MSB; the sticky zero flag carries the scan
  // across chunk boundaries so a 1 after any earlier 0 marks the lane bad.
  always_comb begin
    for (int unsigned l = 0; l < KERNEL_SIZE; l++) begin
      zero_seen_next[l] = zero_seen[l];
      err_next[l]       = err_acc[l];
      for (int unsigned b = 0; b < CHUNK; b++) begin
        if (chunk_bits[l][b] && zero_seen_next[l]) err_next[l] = 1'b1;
        if (!chunk_bits[l][b])                      zero_seen_next[l] = 1'b1;
      end
    end
  end
`endif

  // Datapath: buffer, accumulators, chunk index and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer       <= '0;
      cnt          <= '0;
      idx          <= '0;
      io.pixel_out <= '0;
`ifdef BINARIZATION_DECODE_CHECK_EN
      zero_seen    <= '0;
      err_acc      <= '0;
      io.out_err   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            buffer     <= io.code_in;
            cnt        <= '0;
            idx        <= '0;
`ifdef BINARIZATION_DECODE_CHECK_EN
            zero_seen  <= '0;
            err_acc    <= '0;
            io.out_err <= '0;
`endif
          end
        end
        ACCUM: begin
          cnt <= cnt_next;
          idx <= idx + 1'b1;
`ifdef BINARIZATION_DECODE_CHECK_EN
          zero_seen <= zero_seen_next;
          err_acc   <= err_next;
`endif
          if (last_chunk) begin
            io.pixel_out <= pix_next;
`ifdef BINARIZATION_DECODE_CHECK_EN
            io.out_err   <= err_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binarization_decode.sv
// tb_binarization_decode: self-checking bench for binarization_decode.
// Table-driven vectors plus hand sequences for backpressure, reset during
// counting, malformed codes and back-to-back throughput. Expected results go
// into a scoreboard queue at acceptance and are popped when out_valid rises.
// Honours BINARIZATION_DECODE_CHECK_EN for the out_err comparisons.
module tb_binarization_decode;

  import binarization_pkg::*;

  localparam int K      = KERNEL_SIZE;
  localparam int C      = CHANNEL_CNT;
  localparam int BW     = BIT_WIDTH;
  localparam int CH     = 32;
  localparam int NCHUNK = C / CH;

  typedef logic [K-1:0][C-1:0]  code_t;
  typedef logic [K-1:0][BW-1:0] pix_t;

  typedef struct {
    pix_t           pix;
    logic [K-1:0]   err;
  } exp_t;

  typedef struct {
    int         n0;     // ones in lane 0
    int         nr;     // ones in lanes 1..K-1
    bit         msb;    // pack ones from the MSB instead of the LSB
    logic [7:0] e0;     // expected pixel lane 0
    logic [7:0] er;     // expected pixel lanes 1..K-1
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binarization_decode_if bus ();

  binarization_decode #(
    .KERNEL_SIZE (K),
    .BIT_WIDTH   (BW),
    .CHANNEL_CNT (C),
    .CHUNK       (CH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [C-1:0] mk(input int n, input bit msb);
    logic [C-1:0] r;
    r = '0;
    for (int i = 0; i < C; i++) r[i] = msb ? (i >= C - n) : (i < n);
    return r;
  endfunction

  // Reference decoder: popcount, offset, clamp; error if not LSB-packed.
  function automatic exp_t model(input code_t c);
    exp_t e;
    for (int l = 0; l < K; l++) begin
      int cnt;
      int v;
      cnt = 0;
      for (int i = 0; i < C; i++) cnt += int'(c[l][i]);
      v = cnt - C / 2;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      e.pix[l] = BW'(v);
      e.err[l] = (c[l] != mk(cnt, 1'b0));
    end
    return e;
  endfunction

  task automatic send(input code_t c, input exp_t e, input string name);
    for (int t = 0; t < 40 && !bus.in_ready; t++) @(negedge clk);
    check({name, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    bus.code_in  = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Called at the first negedge after acceptance; returns negedges counted
  // from that point (inclusive) until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_sb: got output expected none pending", name);
    end else begin
      e = sb.pop_front();
      check({name, "_pixel"}, 128'(bus.pixel_out), 128'(e.pix));
`ifdef BINARIZATION_DECODE_CHECK_EN
      check({name, "_err"}, 128'(bus.out_err), 128'(e.err));
`endif
    end
  endtask

  task automatic run(input code_t c, input exp_t e, input string name);
    int lat;
    send(c, e, name);
    wait_out(lat);
    check({name, "_latency"}, 128'(lat), 128'(NCHUNK + 1));
    check_out(name);
    @(negedge clk);
    check({name, "_out_valid_after"}, 128'(bus.out_valid), 128'(0));
    check({name, "_in_ready_after"}, 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    vec_t  tbl[8];
    code_t c;
    code_t c2;
    exp_t  e;
    exp_t  e2;
    int    lat;
    int    t1;
    int    t2;
    bit    prev;
    bit    bpushed;

    tbl[0] = '{n0: 128, nr: 0,   msb: 1'b0, e0: 8'h00, er: 8'h80};
    tbl[1] = '{n0: 255, nr: 1,   msb: 1'b0, e0: 8'h7F, er: 8'h81};
    tbl[2] = '{n0: 256, nr: 256, msb: 1'b0, e0: 8'h7F, er: 8'h7F};
    tbl[3] = '{n0: 1,   nr: 128, msb: 1'b0, e0: 8'h81, er: 8'h00};
    tbl[4] = '{n0: 0,   nr: 200, msb: 1'b1, e0: 8'h80, er: 8'h48};
    tbl[5] = '{n0: 130, nr: 127, msb: 1'b1, e0: 8'h02, er: 8'hFF};
    tbl[6] = '{n0: 64,  nr: 192, msb: 1'b0, e0: 8'hC0, er: 8'h40};
    tbl[7] = '{n0: 256, nr: 0,   msb: 1'b1, e0: 8'h7F, er: 8'h80};

    bus.in_valid  = 1'b0;
    bus.code_in   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_pixel", 128'(bus.pixel_out), 128'(0));
`ifdef BINARIZATION_DECODE_CHECK_EN
    check("reset_err", 128'(bus.out_err), 128'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      for (int l = 0; l < K; l++) begin
        int n;
        n = (l == 0) ? tbl[v].n0 : tbl[v].nr;
        c[l]     = mk(n, tbl[v].msb);
        e.pix[l] = (l == 0) ? tbl[v].e0 : tbl[v].er;
        e.err[l] = tbl[v].msb && (n > 0) && (n < C);
      end
      run(c, e, $sformatf("tbl%0d", v));
    end

    // Malformed codes: single high bit, valid code, chunk-boundary gap
    c = '0;
    c[3][200] = 1'b1;
    c[4] = mk(100, 1'b0);
    c[5] = mk(31, 1'b0);
    c[5][32] = 1'b1;
    run(c, model(c), "malformed");
    check("malformed_lane3_pixel", 128'(bus.pixel_out[3]), 128'(8'h81));
    check("malformed_lane4_pixel", 128'(bus.pixel_out[4]), 128'(8'hE4));
    check("malformed_lane5_pixel", 128'(bus.pixel_out[5]), 128'(8'hA0));
`ifdef BINARIZATION_DECODE_CHECK_EN
    check("malformed_lane3_err", 128'(bus.out_err[3]), 128'(1));
    check("malformed_lane4_err", 128'(bus.out_err[4]), 128'(0));
    check("malformed_lane5_err", 128'(bus.out_err[5]), 128'(1));
`endif

    // Backpressure: hold out_ready low 5 cycles with a competing in_valid
    for (int l = 0; l < K; l++) c[l] = mk(90 + l, 1'b0);
    e = model(c);
    send(c, e, "bp");
    wait_out(lat);
    check("bp_latency", 128'(lat), 128'(NCHUNK + 1));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.code_in   = '1;
    check_out("bp_first");
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("bp_hold_valid", 128'(bus.out_valid), 128'(1));
      check("bp_hold_pixel", 128'(bus.pixel_out), 128'(e.pix));
      check("bp_hold_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 128'(bus.out_valid), 128'(0));
    check("bp_release_in_ready", 128'(bus.in_ready), 128'(1));
    check("bp_release_pixel_hold", 128'(bus.pixel_out), 128'(e.pix));
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Reset while counting chunk 4; partial result must vanish
    for (int l = 0; l < K; l++) c[l] = mk(20 * l + 5, 1'b0);
    send(c, model(c), "rst");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_pixel", 128'(bus.pixel_out), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int l = 0; l < K; l++) c[l] = mk(200 - 10 * l, 1'b0);
    run(c, model(c), "post_rst");

    // Back-to-back: B held on code_in during A's counting must not leak in
    for (int l = 0; l < K; l++) c[l]  = mk(3 * l + 140, 1'b0);
    for (int l = 0; l < K; l++) c2[l] = mk(60 - 5 * l, 1'b1);
    e  = model(c);
    e2 = model(c2);
    bus.code_in  = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.code_in = c2;
    t1 = -1;
    t2 = -1;
    prev = 1'b0;
    bpushed = 1'b0;
    for (int t = 0; t < 60 && t2 < 0; t++) begin
      if (t > 0) @(negedge clk);
      if (bus.out_valid && !prev) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
        check_out("b2b");
      end
      prev = bus.out_valid;
      if (bpushed && !bus.in_ready) bus.in_valid = 1'b0;
      if (!bpushed && bus.in_valid && bus.in_ready) begin
        sb.push_back(e2);
        bpushed = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_spacing", 128'(t2 - t1), 128'(NCHUNK + 2));
    check("b2b_sb_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
